// File: rtl/video2ram_ring_if.sv
// RAM write-port bundle between the video capture stage and the line-buffer RAM.
interface video2ram_ring_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 14
);
  logic [DATA_WIDTH-1:0] wrdata;
  logic [ADDR_WIDTH-1:0] wraddr;
  logic                  wren;

  modport master (output wrdata, output wraddr, output wren);
  modport slave  (input  wrdata, input  wraddr, input  wren);
endinterface

// File: rtl/video2ram_ring.sv
// Captures the active video window into a line-based ring buffer in dual-port
// RAM. Window geometry is shadowed once per frame, interlaced sources fill the
// ring once per field, and a start pulse tells the reader when enough lines
// of the current field are buffered.
module video2ram_ring #(
  parameter int DATA_WIDTH   = 24,
  parameter int ADDR_WIDTH   = 14,
  parameter int LINE_LENGTH  = 640,
  parameter int NUM_LINES    = 16,
  parameter int TRIGGER_LINE = 8,
  parameter int CW           = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  input  logic [CW-1:0]         counterX,
  input  logic [CW-1:0]         counterY,
  input  logic                  interlaced,
  input  logic [CW-1:0]         h_start,
  input  logic [CW-1:0]         h_end,
  input  logic [CW-1:0]         v_start,
  input  logic [CW-1:0]         v_end,
  input  logic [CW-1:0]         f2_v_start,
  input  logic [CW-1:0]         f2_v_end,
  video2ram_ring_if.master      ram,
  output logic                  starttrigger,
  output logic                  line_done,
  output logic                  field
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int LCW = $clog2(NUM_LINES + 1);
  localparam logic [31:0]    LL32      = 32'(LINE_LENGTH);
  localparam logic [AW1-1:0] LINE_STEP = AW1'(LINE_LENGTH);
  localparam logic [AW1-1:0] RING_END  = AW1'(NUM_LINES * LINE_LENGTH);
  localparam logic [AW1-1:0] TRIG_ADDR = AW1'(TRIGGER_LINE * LINE_LENGTH);
  localparam logic [LCW-1:0] LINE_SAT  = LCW'(NUM_LINES);

  // Shadowed window configuration
  logic          sh_interlaced;
  logic [CW-1:0] sh_h_start, sh_h_end, sh_v_start, sh_v_end;
  logic [CW-1:0] sh_f2_v_start, sh_f2_v_end;

  // Ring position of the line being captured
  logic [AW1-1:0] line_base;
  logic [LCW-1:0] line_cnt;

  // Write-port pipeline registers
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] wraddr_p1;
  logic [DATA_WIDTH-1:0] wrdata_p1;

  // Decode of the current pixel position against the shadowed window
  logic [CW-1:0]  dx, h_width;
  logic [31:0]    line_words;
  logic           in_h, h_valid, hact, vact0, vact1, vact;
  logic           adv, fs0, fs1, write;
  logic [AW1-1:0] wsum, next_base;

  // Window decode: the line ends at h_end or at the buffer width, whichever is first
  always_comb begin
    dx         = counterX - sh_h_start;
    h_width    = sh_h_end - sh_h_start;
    h_valid    = sh_h_end > sh_h_start;
    line_words = (32'(h_width) < LL32) ? 32'(h_width) : LL32;
    in_h       = counterX >= sh_h_start;
    hact       = in_h && (counterX < sh_h_end) && (32'(dx) < LL32);
    vact0      = (counterY >= sh_v_start) && (counterY < sh_v_end);
    vact1      = sh_interlaced && (counterY >= sh_f2_v_start) && (counterY < sh_f2_v_end);
    vact       = vact0 || vact1;
    write      = hact && vact;
    adv        = vact && h_valid && in_h && (32'(dx) == line_words);
    fs0        = (counterX == '0) && (counterY == sh_v_start);
    fs1        = sh_interlaced && (counterX == '0) && (counterY == sh_f2_v_start);
    wsum       = line_base + AW1'(dx);
    next_base  = line_base + LINE_STEP;
    if (next_base >= RING_END) next_base = '0;
  end

  // Reload the window configuration at reset and at the top-left pixel of each frame
  always_ff @(posedge clock) begin
    if (reset || (counterX == '0 && counterY == '0)) begin
      sh_interlaced <= interlaced;
      sh_h_start    <= h_start;
      sh_h_end      <= h_end;
      sh_v_start    <= v_start;
      sh_v_end      <= v_end;
      sh_f2_v_start <= f2_v_start;
      sh_f2_v_end   <= f2_v_end;
    end
  end

  // Ring position, field tracking and one-cycle status pulses; field start beats line advance
  always_ff @(posedge clock) begin
    if (reset) begin
      line_base    <= '0;
      line_cnt     <= '0;
      field        <= 1'b0;
      vld_p1       <= 1'b0;
      starttrigger <= 1'b0;
      line_done    <= 1'b0;
    end else begin
      // stage p0 -> p1: registered write strobe and status pulses
      vld_p1       <= write;
      starttrigger <= write && (wsum == TRIG_ADDR) && (line_cnt < LINE_SAT);
      line_done    <= adv;
      if (fs0 || fs1) begin
        line_base <= '0;
        line_cnt  <= '0;
        field     <= !fs0;
      end else if (adv) begin
        line_base <= next_base;
        if (line_cnt < LINE_SAT) line_cnt <= line_cnt + 1'b1;
      end
    end
  end

  // Address/data capture for the RAM port; holds its value between writes
  always_ff @(posedge clock) begin
    if (reset) begin
      wraddr_p1 <= '0;
      wrdata_p1 <= '0;
    end else if (write) begin
      wraddr_p1 <= wsum[ADDR_WIDTH-1:0];
      wrdata_p1 <= pixel_data;
    end
  end

  assign ram.wren   = vld_p1;
  assign ram.wraddr = wraddr_p1;
  assign ram.wrdata = wrdata_p1;

endmodule

// File: tb/tb_video2ram_ring.sv
// Directed bench for video2ram_ring with an 8-word, 4-line ring and a
// 24x16 raster.
module tb_video2ram_ring;

  localparam int DW = 24;
  localparam int AW = 14;
  localparam int CW = 12;
  localparam int HT = 24;
  localparam int VT = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] pixel_data = '0;
  logic [CW-1:0] counterX = '0, counterY = '0;
  logic          interlaced = 1'b0;
  logic [CW-1:0] h_start = '0, h_end = '0, v_start = '0, v_end = '0;
  logic [CW-1:0] f2_v_start = '0, f2_v_end = '0;
  logic          starttrigger, line_done, field;

  int passed = 0;
  int total  = 0;

  video2ram_ring_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram ();

  video2ram_ring #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_LENGTH(8), .NUM_LINES(4),
    .TRIGGER_LINE(1), .CW(CW)
  ) dut (
    .clock(clock), .reset(reset), .pixel_data(pixel_data),
    .counterX(counterX), .counterY(counterY), .interlaced(interlaced),
    .h_start(h_start), .h_end(h_end), .v_start(v_start), .v_end(v_end),
    .f2_v_start(f2_v_start), .f2_v_end(f2_v_end), .ram(ram),
    .starttrigger(starttrigger), .line_done(line_done), .field(field)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] pix(input int x, input int y);
    return {8'h5A, 8'(y), 8'(x)};
  endfunction

  task automatic set_cfg(input int hs, input int he, input int vs, input int ve,
                         input int f2s, input int f2e, input logic il);
    h_start = CW'(hs); h_end = CW'(he); v_start = CW'(vs); v_end = CW'(ve);
    f2_v_start = CW'(f2s); f2_v_end = CW'(f2e); interlaced = il;
  endtask

  // Present one pixel position and advance one clock; outputs are read 1 time unit after the edge
  task automatic cyc(input int x, input int y);
    counterX = CW'(x); counterY = CW'(y); pixel_data = pix(x, y);
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    set_cfg(4, 12, 0, 6, 10, 13, 1'b0);
    reset = 1'b1;
    cyc(5, 3);
    reset = 1'b0;
    total++; if (ram.wren !== 1'b0) $display("FAIL reset_wren got %0b want 0", ram.wren); else passed++;
    total++; if (ram.wraddr !== '0) $display("FAIL reset_wraddr got %0d want 0", ram.wraddr); else passed++;
    total++; if (ram.wrdata !== '0) $display("FAIL reset_wrdata got %h want 0", ram.wrdata); else passed++;
    total++; if (starttrigger !== 1'b0) $display("FAIL reset_trig got %0b want 0", starttrigger); else passed++;
    total++; if (line_done !== 1'b0) $display("FAIL reset_line_done got %0b want 0", line_done); else passed++;
    total++; if (field !== 1'b0) $display("FAIL reset_field got %0b want 0", field); else passed++;
  endtask

  task automatic test_progressive();
    logic ew;
    logic [AW-1:0] ea;
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        cyc(x, y);
        ew = (y < 6) && (x >= 4) && (x < 12);
        ea = AW'((y % 4) * 8 + x - 4);
        total++; if (ram.wren !== ew) $display("FAIL prog_wren x=%0d y=%0d got %0b want %0b", x, y, ram.wren, ew); else passed++;
        if (ew) begin
          total++; if (ram.wraddr !== ea) $display("FAIL prog_addr x=%0d y=%0d got %0d want %0d", x, y, ram.wraddr, ea); else passed++;
          total++; if (ram.wrdata !== pix(x, y)) $display("FAIL prog_data x=%0d y=%0d got %h want %h", x, y, ram.wrdata, pix(x, y)); else passed++;
        end
        if (x == 12 && y == 0) begin
          total++; if (ram.wraddr !== AW'(7)) $display("FAIL prog_addr_hold got %0d want 7", ram.wraddr); else passed++;
        end
        total++; if (line_done !== ((y < 6) && (x == 12))) $display("FAIL prog_line_done x=%0d y=%0d got %0b", x, y, line_done); else passed++;
        total++; if (starttrigger !== ((y == 1) && (x == 4))) $display("FAIL prog_trig x=%0d y=%0d got %0b", x, y, starttrigger); else passed++;
        total++; if (field !== 1'b0) $display("FAIL prog_field x=%0d y=%0d got %0b want 0", x, y, field); else passed++;
      end
    end
  endtask

  task automatic test_clipping();
    logic ew;
    set_cfg(4, 20, 0, 6, 10, 13, 1'b0);
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        cyc(x, y);
        ew = (y < 6) && (x >= 4) && (x < 12);
        total++; if (ram.wren !== ew) $display("FAIL clip_wren x=%0d y=%0d got %0b want %0b", x, y, ram.wren, ew); else passed++;
        if (ew) begin
          total++; if (ram.wraddr !== AW'((y % 4) * 8 + x - 4)) $display("FAIL clip_addr x=%0d y=%0d got %0d", x, y, ram.wraddr); else passed++;
        end
        total++; if (line_done !== ((y < 6) && (x == 12))) $display("FAIL clip_line_done x=%0d y=%0d got %0b", x, y, line_done); else passed++;
        total++; if (starttrigger !== ((y == 1) && (x == 4))) $display("FAIL clip_trig x=%0d y=%0d got %0b", x, y, starttrigger); else passed++;
      end
    end
  endtask

  task automatic test_interlaced();
    logic ew, act;
    int   ln, ntrig;
    ntrig = 0;
    set_cfg(4, 12, 0, 3, 10, 13, 1'b1);
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        cyc(x, y);
        act = (y < 3) || (y >= 10 && y < 13);
        ln  = (y >= 10) ? y - 10 : y;
        ew  = act && (x >= 4) && (x < 12);
        if (starttrigger === 1'b1) ntrig++;
        total++; if (ram.wren !== ew) $display("FAIL il_wren x=%0d y=%0d got %0b want %0b", x, y, ram.wren, ew); else passed++;
        if (ew) begin
          total++; if (ram.wraddr !== AW'(ln * 8 + x - 4)) $display("FAIL il_addr x=%0d y=%0d got %0d want %0d", x, y, ram.wraddr, ln * 8 + x - 4); else passed++;
        end
        total++; if (field !== (y >= 10)) $display("FAIL il_field x=%0d y=%0d got %0b", x, y, field); else passed++;
        total++; if (line_done !== (act && x == 12)) $display("FAIL il_line_done x=%0d y=%0d got %0b", x, y, line_done); else passed++;
        total++; if (starttrigger !== (x == 4 && (y == 1 || y == 11))) $display("FAIL il_trig x=%0d y=%0d got %0b", x, y, starttrigger); else passed++;
      end
    end
    total++; if (ntrig !== 2) $display("FAIL il_trig_count got %0d want 2", ntrig); else passed++;
  endtask

  task automatic test_shadow();
    logic ew;
    int   hs;
    set_cfg(4, 12, 0, 6, 10, 13, 1'b0);
    for (int f = 0; f < 2; f++) begin
      hs = (f == 0) ? 4 : 6;
      for (int y = 0; y < VT; y++) begin
        for (int x = 0; x < HT; x++) begin
          if (f == 0 && y == 2 && x == 0) h_start = CW'(6);
          cyc(x, y);
          ew = (y < 6) && (x >= hs) && (x < 12);
          total++; if (ram.wren !== ew) $display("FAIL shadow_wren f=%0d x=%0d y=%0d got %0b want %0b", f, x, y, ram.wren, ew); else passed++;
          if (ew) begin
            total++; if (ram.wraddr !== AW'((y % 4) * 8 + x - hs)) $display("FAIL shadow_addr f=%0d x=%0d y=%0d got %0d want %0d", f, x, y, ram.wraddr, (y % 4) * 8 + x - hs); else passed++;
          end
          total++; if (line_done !== ((y < 6) && (x == 12))) $display("FAIL shadow_line_done f=%0d x=%0d y=%0d got %0b", f, x, y, line_done); else passed++;
          total++; if (starttrigger !== ((y == 1) && (x == hs))) $display("FAIL shadow_trig f=%0d x=%0d y=%0d got %0b", f, x, y, starttrigger); else passed++;
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    logic ew;
    set_cfg(4, 12, 0, 3, 10, 13, 1'b1);
    for (int y = 0; y < 11; y++)
      for (int x = 0; x < HT; x++) cyc(x, y);
    for (int x = 0; x < 10; x++) cyc(x, 11);
    total++; if (ram.wraddr !== AW'(13)) $display("FAIL mid_pre_addr got %0d want 13", ram.wraddr); else passed++;
    total++; if (field !== 1'b1) $display("FAIL mid_pre_field got %0b want 1", field); else passed++;
    reset = 1'b1;
    cyc(10, 11);
    reset = 1'b0;
    total++; if (ram.wren !== 1'b0) $display("FAIL mid_wren got %0b want 0", ram.wren); else passed++;
    total++; if (ram.wraddr !== '0) $display("FAIL mid_wraddr got %0d want 0", ram.wraddr); else passed++;
    total++; if (field !== 1'b0) $display("FAIL mid_field got %0b want 0", field); else passed++;
    total++; if (starttrigger !== 1'b0) $display("FAIL mid_trig got %0b want 0", starttrigger); else passed++;
    set_cfg(4, 12, 0, 6, 10, 13, 1'b0);
    for (int x = 11; x < HT; x++) cyc(x, 11);
    for (int y = 12; y < VT; y++)
      for (int x = 0; x < HT; x++) cyc(x, y);
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        cyc(x, y);
        ew = (y < 6) && (x >= 4) && (x < 12);
        total++; if (ram.wren !== ew) $display("FAIL post_wren x=%0d y=%0d got %0b want %0b", x, y, ram.wren, ew); else passed++;
        if (ew) begin
          total++; if (ram.wraddr !== AW'((y % 4) * 8 + x - 4)) $display("FAIL post_addr x=%0d y=%0d got %0d", x, y, ram.wraddr); else passed++;
        end
        total++; if (starttrigger !== ((y == 1) && (x == 4))) $display("FAIL post_trig x=%0d y=%0d got %0b", x, y, starttrigger); else passed++;
      end
    end
  endtask

  task automatic test_degenerate();
    set_cfg(5, 5, 0, 6, 10, 13, 1'b0);
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        cyc(x, y);
        total++; if (ram.wren !== 1'b0) $display("FAIL degen_wren x=%0d y=%0d got %0b want 0", x, y, ram.wren); else passed++;
        total++; if (line_done !== 1'b0) $display("FAIL degen_line_done x=%0d y=%0d got %0b want 0", x, y, line_done); else passed++;
        total++; if (starttrigger !== 1'b0) $display("FAIL degen_trig x=%0d y=%0d got %0b want 0", x, y, starttrigger); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_progressive();
    test_clipping();
    test_interlaced();
    test_shadow();
    test_reset_midline();
    test_degenerate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/video2ram_ring.md
Name: video2ram_ring

Overview:
Parametrised capture stage that writes the active video window into a line-based ring buffer in dual-port RAM. The downstream output/scaler side reads from the other port. It sits between the video decoder (which supplies pixel data plus counterX/counterY) and the line-buffer RAM. It replaces the fixed-window capture with run-time window registers, progressive and interlaced (two-field) modes, horizontal clipping to the buffer width, and a once-per-field start trigger.

Parameters:
DATA_WIDTH, 24, pixel word width ({R,G,B} packed by the caller)
ADDR_WIDTH, 14, RAM word-address width
LINE_LENGTH, 640, RAM words per buffered line
NUM_LINES, 16, lines in the ring; NUM_LINES*LINE_LENGTH must be <= 2^ADDR_WIDTH
TRIGGER_LINE, 8, ring line whose first pixel write fires starttrigger; must be < NUM_LINES
CW, 12, counter and window-register width

Ports:
clock  in  1  pixel clock; the only clock
reset  in  1  synchronous, active-high reset
pixel_data  in  DATA_WIDTH  pixel for the current counterX/counterY
counterX  in  CW  horizontal position
counterY  in  CW  vertical position
interlaced  in  1  1 = two-field mode, 0 = progressive
h_start  in  CW  first captured X (inclusive)
h_end  in  CW  capture end X (exclusive)
v_start  in  CW  field-0 first line (inclusive)
v_end  in  CW  field-0 end line (exclusive)
f2_v_start  in  CW  field-1 first line (inclusive); ignored when interlaced=0
f2_v_end  in  CW  field-1 end line (exclusive)
wrdata  out  DATA_WIDTH  RAM write data
wraddr  out  ADDR_WIDTH  RAM write address
wren  out  1  RAM write enable
starttrigger  out  1  one-cycle pulse, reader may start
line_done  out  1  one-cycle pulse after the last pixel of each captured line
field  out  1  field of the current/last captured line (0 or 1)

Behaviour:
- Shadow config:
  - interlaced, h_start..f2_v_end are latched into shadow registers on reset and when counterX==0 && counterY==0.
  - All other logic uses only the shadow copies. Mid-frame input changes have no effect until the next frame.
- Vertical activity:
  - vact0 = v_start <= Y < v_end.
  - vact1 = interlaced && f2_v_start <= Y < f2_v_end.
  - vact = vact0 | vact1. If both windows hit, field 0 wins.
- Horizontal activity: hact = h_start <= X < h_end && (X - h_start) < LINE_LENGTH.
  - Pixels beyond LINE_LENGTH are clipped, not wrapped.
  - h_end <= h_start means no writes.
- Field start: at counterX==0 and Y==v_start (or Y==f2_v_start in interlaced mode):
  - line_base <= 0, line_cnt <= 0.
  - field <= 0 or 1 respectively.
- Line advance: on the cycle X == h_end with vact, or X - h_start == LINE_LENGTH with vact, whichever comes first on that line:
  - line_base += LINE_LENGTH, wrapping to 0 when the result would reach NUM_LINES*LINE_LENGTH.
  - line_cnt increments, saturating at NUM_LINES.
  - line_done pulses exactly once per captured line.
  - If h_end >= horizontal total, no advance and no line_done occur for that line.
- Field start at the same cycle as an advance event: field start wins.
- Write pipeline: exactly 1 cycle of latency. When hact && vact at edge N, then at edge N+1:
  - wren=1
  - wraddr = line_base + (X - h_start), truncated to ADDR_WIDTH
  - wrdata = pixel_data sampled at edge N
  - Otherwise wren=0 and wraddr/wrdata hold their last values.
- starttrigger:
  - Pulses in the same cycle wren asserts for address TRIGGER_LINE*LINE_LENGTH, but only while line_cnt < NUM_LINES (first ring pass of the current field).
  - Result: one pulse per field in interlaced mode, one per frame in progressive mode. It never pulses on wrapped passes.
- Reset, including mid-line or mid-frame: at the next edge wren=0, starttrigger=0, line_done=0, field=0, wraddr=0, wrdata=0, line_base=0, line_cnt=0. The shadow config reloads from the inputs.
- Widths: all counter comparisons are unsigned in CW bits. Address arithmetic is done in ADDR_WIDTH+1 bits before the wrap check.

Test Plan:
1. Progressive, LINE_LENGTH=8, NUM_LINES=4, TRIGGER_LINE=1, h=[4,12), v=[0,6):
   - Line 0 writes addr 0..7 with wren high for 8 cycles, 1 cycle after X=4..11.
   - line_done pulses at X=12+1.
   - Lines 4 and 5 wrap to addr 0..7 and 8..15.
   - starttrigger fires once, on addr 8 of line 1.
2. Clipping, h=[4,20), LINE_LENGTH=8: only X=4..11 are written.
   - line_done pulses once per line, following X=12.
   - No address >= line_base+8 is ever written.
3. Interlaced, v=[0,3), f2=[10,13):
   - Line 10 restarts at addr 0 with field=1.
   - starttrigger fires once per field: 2 pulses per frame.
   - Lines 3..9 produce wren=0 throughout.
4. Change h_start from 4 to 6 while counterY=2:
   - The current frame still writes from X=4.
   - After X=0,Y=0 the capture starts at X=6 with addr offset 0.
5. Assert reset for 1 cycle mid-line at addr 13:
   - The next cycle has wren=0, wraddr=0, field=0.
   - The next v_start line writes from addr 0.
   - starttrigger fires again on the first pass.
6. Degenerate window h_start=h_end=5: wren, line_done and starttrigger stay 0 for a full frame.
